regfile_param: RTL and testbench

- Parametrised successor to the 8x10 register file: DEPTH x WIDTH storage, one write port, two independently enabled registered read ports.
- Adds synchronous reset, optional hardwired zero register, optional write-to-read bypass, and per-port valid flags.
- Sits in the datapath between the operand bus D and the ALU operand inputs Q0/Q1.

---
 rtl/regfile_param.sv | 117 +++++++++++
 tb/tb_regfile_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: DEPTH x WIDTH register file with one write port and two
// independently enabled, registered read ports. All state changes on the
// falling edge of CLKb.
//
// Ports:
//   CLKb        clock, falling-edge active
//   RST         synchronous active-high reset
//   D/ENW/WRA   write data, write enable, write address
//   ENR0/RDA0   read port 0 enable and address
//   ENR1/RDA1   read port 1 enable and address
//   Q0/Q1       registered read data
//   VLD0/VLD1   read data came from a written register or the zero register
module regfile_param #(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic             CLKb,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             ENW,
    input  logic [AW-1:0]    WRA,
    input  logic             ENR0,
    input  logic [AW-1:0]    RDA0,
    input  logic             ENR1,
    input  logic [AW-1:0]    RDA1,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic             VLD0,
    output logic             VLD1
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic [WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
    logic             vld0_q, vld0_d, vld1_q, vld1_d;
    logic             wr_ok;
    logic [WIDTH:0]   rd0_sel, rd1_sel;

    // Returns {valid, data} for one read address, in priority order:
    // out of range, zero register, same-cycle bypass, stored contents.
    function automatic logic [WIDTH:0] rd_sel(input logic [AW-1:0] a);
        logic [WIDTH:0] r;
        r = '0;
        if (int'(a) >= DEPTH) begin
            r = '0;
        end else if (ZERO_REG != 0 && a == '0) begin
            r = {1'b1, {WIDTH{1'b0}}};
        end else if (BYPASS != 0 && wr_ok && WRA == a) begin
            r = {1'b1, D};
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (a == AW'(i)) begin
                    r = {written_q[i], mem_q[i]};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        wr_ok     = ENW && (int'(WRA) < DEPTH) && !(ZERO_REG != 0 && WRA == '0);
        mem_d     = mem_q;
        written_d = written_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_ok && WRA == AW'(i)) begin
                mem_d[i]     = D;
                written_d[i] = 1'b1;
            end
        end

        rd0_sel = rd_sel(RDA0);
        rd1_sel = rd_sel(RDA1);

        q0_d   = q0_q;
        vld0_d = vld0_q;
        q1_d   = q1_q;
        vld1_d = vld1_q;
        if (ENR0) begin
            q0_d   = rd0_sel[WIDTH-1:0];
            vld0_d = rd0_sel[WIDTH];
        end
        if (ENR1) begin
            q1_d   = rd1_sel[WIDTH-1:0];
            vld1_d = rd1_sel[WIDTH];
        end
    end

    always_ff @(negedge CLKb) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q <= '0;
            q0_q      <= '0;
            q1_q      <= '0;
            vld0_q    <= 1'b0;
            vld1_q    <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            written_q <= written_d;
            q0_q      <= q0_d;
            q1_q      <= q1_d;
            vld0_q    <= vld0_d;
            vld1_q    <= vld1_d;
        end
    end

    assign Q0   = q0_q;
    assign Q1   = q1_q;
    assign VLD0 = vld0_q;
    assign VLD1 = vld1_q;

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: two instances share one stimulus stream,
// the default configuration (8 regs, bypass on, no zero reg) and an
// alternate one (6 regs, zero register on, bypass off). Each instance is
// compared against a behavioural array model after every falling edge.
module tb_regfile_param;

    logic       CLKb = 1'b1;
    logic       RST  = 1'b1;
    logic [9:0] D    = '0;
    logic       ENW  = 1'b0;
    logic [2:0] WRA  = '0;
    logic       ENR0 = 1'b0;
    logic [2:0] RDA0 = '0;
    logic       ENR1 = 1'b0;
    logic [2:0] RDA1 = '0;

    logic [9:0] q0_a, q1_a, q0_b, q1_b;
    logic       v0_a, v1_a, v0_b, v1_b;

    int checks = 0;
    int errors = 0;

    always #5 CLKb = ~CLKb;

    regfile_param u_dflt (
        .CLKb(CLKb), .RST(RST), .D(D), .ENW(ENW), .WRA(WRA),
        .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
        .Q0(q0_a), .Q1(q1_a), .VLD0(v0_a), .VLD1(v1_a)
    );

    regfile_param #(.WIDTH(10), .DEPTH(6), .ZERO_REG(1), .BYPASS(0)) u_alt (
        .CLKb(CLKb), .RST(RST), .D(D), .ENW(ENW), .WRA(WRA),
        .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
        .Q0(q0_b), .Q1(q1_b), .VLD0(v0_b), .VLD1(v1_b)
    );

    // Reference model, index 0 = u_dflt, index 1 = u_alt
    int         dep [2] = '{8, 6};
    bit         zr  [2] = '{1'b0, 1'b1};
    bit         bp  [2] = '{1'b1, 1'b0};
    logic [9:0] mm  [2][8];
    bit         mw  [2][8];
    logic [9:0] mq0 [2], mq1 [2];
    bit         mv0 [2], mv1 [2];

    function automatic bit legal(int k);
        return ENW && (int'(WRA) < dep[k]) && !(zr[k] && WRA == 0);
    endfunction

    function automatic void model_read(int k, logic [2:0] a,
                                       output logic [9:0] dat, output bit v);
        if (int'(a) >= dep[k]) begin
            dat = 0; v = 0;
        end else if (zr[k] && a == 0) begin
            dat = 0; v = 1;
        end else if (bp[k] && legal(k) && WRA == a) begin
            dat = D; v = 1;
        end else begin
            dat = mm[k][a]; v = mw[k][a];
        end
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                for (int i = 0; i < 8; i++) begin
                    mm[k][i] = 0;
                    mw[k][i] = 0;
                end
                mq0[k] = 0; mq1[k] = 0; mv0[k] = 0; mv1[k] = 0;
            end else begin
                if (ENR0) model_read(k, RDA0, mq0[k], mv0[k]);
                if (ENR1) model_read(k, RDA1, mq1[k], mv1[k]);
                if (legal(k)) begin
                    mm[k][WRA] = D;
                    mw[k][WRA] = 1;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("dflt_q0", 32'(q0_a), 32'(mq0[0]));
        chk("dflt_q1", 32'(q1_a), 32'(mq1[0]));
        chk("dflt_v0", 32'(v0_a), 32'(mv0[0]));
        chk("dflt_v1", 32'(v1_a), 32'(mv1[0]));
        chk("alt_q0",  32'(q0_b), 32'(mq0[1]));
        chk("alt_q1",  32'(q1_b), 32'(mq1[1]));
        chk("alt_v0",  32'(v0_b), 32'(mv0[1]));
        chk("alt_v1",  32'(v1_b), 32'(mv1[1]));
    endtask

    // Inputs are already applied; update the model, take one falling edge,
    // then sample the DUTs 1 time unit later.
    task automatic step();
        model_edge();
        @(negedge CLKb);
        #1;
        chk_model();
    endtask

    task automatic set_in(bit rst, bit enw, logic [2:0] wra, logic [9:0] d,
                          bit enr0, logic [2:0] rda0, bit enr1, logic [2:0] rda1);
        RST = rst; ENW = enw; WRA = wra; D = d;
        ENR0 = enr0; RDA0 = rda0; ENR1 = enr1; RDA1 = rda1;
    endtask

    logic [9:0] held;

    initial begin
        // Initial reset
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_q0", 32'(q0_a), 0);
        chk("rst_v1", 32'(v1_b), 0);

        // Reset clears a written register
        set_in(0, 1, 3, 10'h155, 0, 0, 0, 0);
        step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1, 3, 1, 3);
        step();
        chk("rstclr_q0", 32'(q0_a), 0);
        chk("rstclr_q1", 32'(q1_a), 0);
        chk("rstclr_v0", 32'(v0_a), 0);
        chk("rstclr_v1", 32'(v1_b), 0);

        // Write then read with one-edge latency; port 1 holds
        set_in(0, 1, 5, 10'h2AA, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1, 5, 0, 2);
        step();
        chk("wr_rd_q0", 32'(q0_a), 32'h2AA);
        chk("wr_rd_v0", 32'(v0_a), 1);
        chk("wr_rd_q1_hold", 32'(q1_a), 0);

        // Bypass vs. no bypass on the same edge
        set_in(0, 1, 2, 10'h011, 0, 0, 0, 0);
        step();
        set_in(0, 1, 2, 10'h3FF, 1, 2, 0, 0);
        step();
        chk("bypass_on_q0", 32'(q0_a), 32'h3FF);
        chk("bypass_off_q0", 32'(q0_b), 32'h011);
        set_in(0, 0, 0, 0, 1, 2, 0, 0);
        step();
        chk("bypass_off_next", 32'(q0_b), 32'h3FF);

        // Zero register
        set_in(0, 1, 0, 10'h123, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1, 0, 1, 0);
        step();
        chk("zero_q0", 32'(q0_b), 0);
        chk("zero_q1", 32'(q1_b), 0);
        chk("zero_v0", 32'(v0_b), 1);
        chk("zero_v1", 32'(v1_b), 1);
        chk("nozero_q0", 32'(q0_a), 32'h123);

        // Out-of-range write/read on the 6-deep instance, then sweep
        set_in(0, 1, 7, 10'h0F0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 7);
        step();
        chk("oor_q1", 32'(q1_b), 0);
        chk("oor_v1", 32'(v1_b), 0);
        chk("inrange_q1", 32'(q1_a), 32'h0F0);
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 0, 1, 3'(i), 0, 0);
            step();
        end
        chk("sweep_r5", 32'(q0_b), 32'h2AA);

        // Hold: Q0 frozen while ENR0=0 and RDA0 toggles
        set_in(0, 0, 0, 0, 1, 5, 0, 0);
        step();
        held = q0_a;
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0, 0, 3'((i % 2 == 0) ? 2 : 5), 0, 0);
            step();
        end
        chk("hold_q0", 32'(q0_a), 32'h2AA);
        chk("hold_same", 32'(q0_a), 32'(held));

        // Reset wins over a simultaneous write
        set_in(1, 1, 1, 10'h0AB, 1, 1, 1, 1);
        step();
        set_in(0, 0, 0, 0, 1, 1, 0, 0);
        step();
        chk("rstprio_q0", 32'(q0_a), 0);
        chk("rstprio_v0", 32'(v0_a), 0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 31) == 0), 1'($urandom), 3'($urandom),
                   10'($urandom), 1'($urandom), 3'($urandom),
                   1'($urandom), 3'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
